// File: rtl/sdram_arb2.sv
`timescale 1ns/1ps
// sdram_arb2: arbitrates two level-request / pulse-ack clients onto the
// single toggle-handshake port of the SDRAM controller, one transaction at a time.
module sdram_arb2 #(
    parameter bit ROUND_ROBIN = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        a_req,
    input  logic        a_we,
    input  logic [21:1] a_addr,
    input  logic [1:0]  a_ds,
    input  logic [15:0] a_d,
    output logic [15:0] a_q,
    output logic        a_ack,
    input  logic        b_req,
    input  logic        b_we,
    input  logic [21:1] b_addr,
    input  logic [1:0]  b_ds,
    input  logic [15:0] b_d,
    output logic [15:0] b_q,
    output logic        b_ack,
    output logic        mem_req,
    input  logic        mem_ack,
    output logic        mem_we,
    output logic [21:1] mem_a,
    output logic [1:0]  mem_ds,
    output logic [15:0] mem_d,
    input  logic [15:0] mem_q
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state_q, state_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [21:1] mem_a_q, mem_a_d;
    logic [1:0]  mem_ds_q, mem_ds_d;
    logic [15:0] mem_d_q, mem_d_d;
    logic        owner_q, owner_d;   // 1 = B
    logic        last_q, last_d;     // 1 = B granted last
    logic        a_ack_q, a_ack_d, b_ack_q, b_ack_d;
    logic [15:0] a_rd_q, a_rd_d, b_rd_q, b_rd_d;

    logic grant, pick_b, done;

    // The ack cycle blocks a new grant so a client still holding req
    // from the finished transaction is not re-granted on the spot.
    assign grant  = (state_q == IDLE) && (a_req || b_req) && !a_ack_q && !b_ack_q;
    assign pick_b = b_req && (!a_req || (ROUND_ROBIN && !last_q));
    assign done   = (state_q == BUSY) && (mem_ack == mem_req_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            mem_req_q <= mem_ack;
            mem_we_q  <= 1'b0;
            mem_a_q   <= '0;
            mem_ds_q  <= '0;
            mem_d_q   <= '0;
            owner_q   <= 1'b0;
            last_q    <= 1'b1;
            a_ack_q   <= 1'b0;
            b_ack_q   <= 1'b0;
            a_rd_q    <= '0;
            b_rd_q    <= '0;
        end else begin
            state_q   <= state_d;
            mem_req_q <= mem_req_d;
            mem_we_q  <= mem_we_d;
            mem_a_q   <= mem_a_d;
            mem_ds_q  <= mem_ds_d;
            mem_d_q   <= mem_d_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            a_ack_q   <= a_ack_d;
            b_ack_q   <= b_ack_d;
            a_rd_q    <= a_rd_d;
            b_rd_q    <= b_rd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant) state_d = BUSY;
            BUSY:    if (done)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_req_d = mem_req_q;
        mem_we_d  = mem_we_q;
        mem_a_d   = mem_a_q;
        mem_ds_d  = mem_ds_q;
        mem_d_d   = mem_d_q;
        owner_d   = owner_q;
        last_d    = last_q;
        a_ack_d   = 1'b0;
        b_ack_d   = 1'b0;
        a_rd_d    = a_rd_q;
        b_rd_d    = b_rd_q;
        if (grant) begin
            // Derive the toggle from the live ack so stale completions are harmless.
            mem_req_d = ~mem_ack;
            mem_we_d  = pick_b ? b_we   : a_we;
            mem_a_d   = pick_b ? b_addr : a_addr;
            mem_ds_d  = pick_b ? b_ds   : a_ds;
            mem_d_d   = pick_b ? b_d    : a_d;
            owner_d   = pick_b;
            last_d    = pick_b;
        end
        if (done) begin
            if (owner_q) begin
                b_ack_d = 1'b1;
                if (!mem_we_q) b_rd_d = mem_q;
            end else begin
                a_ack_d = 1'b1;
                if (!mem_we_q) a_rd_d = mem_q;
            end
        end
    end

    assign mem_req = mem_req_q;
    assign mem_we  = mem_we_q;
    assign mem_a   = mem_a_q;
    assign mem_ds  = mem_ds_q;
    assign mem_d   = mem_d_q;
    assign a_ack   = a_ack_q;
    assign b_ack   = b_ack_q;
    assign a_q     = a_rd_q;
    assign b_q     = b_rd_q;

endmodule

// File: tb/tb_sdram_arb2.sv
`timescale 1ns/1ps
// Directed bench for sdram_arb2: a round-robin and a fixed-priority instance,
// each behind a fixed-latency toggle-handshake controller model.
module tb_sdram_arb2;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic        a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
    logic [21:1] a_addr = '0, b_addr = '0;
    logic [1:0]  a_ds = '0, b_ds = '0;
    logic [15:0] a_d = '0, b_d = '0;
    logic [15:0] rd_data = '0;

    logic [1:0]  a_ack, b_ack, mem_req, mem_ack, mem_we;
    logic [15:0] a_q [2];
    logic [15:0] b_q [2];
    logic [15:0] mem_d [2];
    logic [15:0] mem_q [2];
    logic [21:1] mem_a [2];
    logic [1:0]  mem_ds [2];

    int nvec = 0;
    int nerr = 0;
    int na [2] = '{0, 0};
    int nb [2] = '{0, 0};

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic [2:0]  cnt = '0;
        logic        ack_m = 1'b1;
        logic [15:0] q_m = '0;

        sdram_arb2 #(.ROUND_ROBIN(g == 0)) u_dut (
            .clk(clk), .reset(reset),
            .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_ds(a_ds), .a_d(a_d),
            .a_q(a_q[g]), .a_ack(a_ack[g]),
            .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_ds(b_ds), .b_d(b_d),
            .b_q(b_q[g]), .b_ack(b_ack[g]),
            .mem_req(mem_req[g]), .mem_ack(mem_ack[g]), .mem_we(mem_we[g]),
            .mem_a(mem_a[g]), .mem_ds(mem_ds[g]), .mem_d(mem_d[g]), .mem_q(mem_q[g])
        );

        assign mem_ack[g] = ack_m;
        assign mem_q[g]   = q_m;

        // Controller: accepts a pending toggle, completes six cycles later by
        // copying the current req into ack (a reset-resynced req yields no toggle).
        always @(posedge clk) begin
            if (cnt != 3'd0) begin
                cnt <= cnt - 3'd1;
                if (cnt == 3'd1) begin
                    ack_m <= mem_req[g];
                    q_m   <= rd_data;
                end
            end else if (mem_req[g] != ack_m) begin
                cnt <= 3'd6;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            if (a_ack[i]) na[i]++;
            if (b_ack[i]) nb[i]++;
        end
    endtask

    task automatic wait_any(input int g, output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!(a_ack[g] || b_ack[g]) && cyc < 40);
        check("ack_timeout", {31'd0, a_ack[g] | b_ack[g]}, 32'd1);
    endtask

    initial begin
        int   cyc;
        int   na0;
        logic r0, r1;

        // Power-up with mem_ack high, then reset
        reset = 1'b1;
        tick();
        tick();
        check("rst_mem_req", mem_req[0], 1);
        check("rst_mem_we",  mem_we[0],  0);
        check("rst_mem_a",   mem_a[0],   0);
        check("rst_mem_ds",  mem_ds[0],  0);
        check("rst_mem_d",   mem_d[0],   0);
        check("rst_acks",    {a_ack[0], b_ack[0]}, 0);
        check("rst_a_q",     a_q[0], 0);
        check("rst_b_q",     b_q[0], 0);
        reset = 1'b0;
        repeat (10) tick();
        check("idle_mem_req", mem_req[0], 1);

        // Single A read
        rd_data = 16'hBEEF; a_addr = 21'h012345; a_we = 1'b0; a_req = 1'b1;
        tick();
        check("t1_mem_req", mem_req[0], 0);
        check("t1_mem_a",   mem_a[0], 21'h012345);
        check("t1_mem_we",  mem_we[0], 0);
        wait_any(0, cyc);
        a_req = 1'b0;
        check("t1_latency", cyc, 8);
        check("t1_a_ack",   a_ack[0], 1);
        check("t1_a_q",     a_q[0], 16'hBEEF);
        tick();
        check("t1_ack_one_cycle", a_ack[0], 0);
        repeat (3) tick();
        check("t1_na", na[0], 1);
        check("t1_nb", nb[0], 0);

        // B write
        rd_data = 16'h1234; b_addr = 21'h1FFFFF; b_ds = 2'b01; b_d = 16'h00A5;
        b_we = 1'b1; b_req = 1'b1;
        tick();
        check("t2_mem_we", mem_we[0], 1);
        check("t2_mem_a",  mem_a[0], 21'h1FFFFF);
        check("t2_mem_ds", mem_ds[0], 2'b01);
        check("t2_mem_d",  mem_d[0], 16'h00A5);
        wait_any(0, cyc);
        b_req = 1'b0; b_we = 1'b0;
        check("t2_b_ack", b_ack[0], 1);
        check("t2_b_q",   b_q[0], 0);
        check("t2_a_q",   a_q[0], 16'hBEEF);
        repeat (3) tick();
        check("t2_nb", nb[0], 1);
        check("t2_na", na[0], 1);

        // Continuous contention: inst0 round-robin, inst1 fixed A priority
        rd_data = 16'h7777; a_addr = 21'h000100; b_addr = 21'h000200;
        a_req = 1'b1; b_req = 1'b1;
        for (int k = 0; k < 6; k++) begin
            wait_any(0, cyc);
            check($sformatf("rr1_grant%0d_is_b", k), b_ack[0], k % 2);
            check($sformatf("rr0_grant%0d_is_a", k), a_ack[1], 1);
        end
        a_req = 1'b0;
        wait_any(1, cyc);
        check("rr0_b_after_a_drop", b_ack[1], 1);
        b_req = 1'b0;
        repeat (4) tick();

        // Reset two cycles after issue; the abandoned read must not ack
        rd_data = 16'h5A5A; a_addr = 21'h000333; a_req = 1'b1;
        tick();
        check("t4_issued", {31'd0, mem_req[0] ^ mem_ack[0]}, 1);
        tick();
        tick();
        reset = 1'b1; a_req = 1'b0;
        na0 = na[0];
        tick();
        reset = 1'b0;
        check("t4_req_resync", {31'd0, mem_req[0] ^ mem_ack[0]}, 0);
        repeat (12) tick();
        check("t4_no_ack",   na[0], na0);
        check("t4_no_issue", {31'd0, mem_req[0] ^ mem_ack[0]}, 0);
        check("t4_a_q_rst",  a_q[0], 0);
        rd_data = 16'hC3C3; a_req = 1'b1;
        tick();
        wait_any(0, cyc);
        a_req = 1'b0;
        check("t4_post_ack", a_ack[0], 1);
        check("t4_post_lat", cyc, 8);
        check("t4_post_q",   a_q[0], 16'hC3C3);
        repeat (3) tick();

        // A held across its ack: back-to-back reissue two cycles after ack
        rd_data = 16'h1111; a_addr = 21'h000444; a_req = 1'b1;
        na0 = na[0];
        tick();
        wait_any(0, cyc);
        check("b2b_q1", a_q[0], 16'h1111);
        r0 = mem_req[0];
        r1 = ~r0;
        rd_data = 16'h2222;
        tick();
        check("b2b_hold",     mem_req[0], r0);
        check("b2b_ack_low",  a_ack[0], 0);
        tick();
        check("b2b_reissue",  mem_req[0], r1);
        wait_any(0, cyc);
        a_req = 1'b0;
        check("b2b_lat2", cyc, 8);
        check("b2b_q2",   a_q[0], 16'h2222);
        repeat (12) tick();
        check("b2b_two_acks", na[0] - na0, 2);
        check("b2b_no_third", {31'd0, mem_req[0] ^ mem_ack[0]}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/sdram_arb2.md
# sdram_arb2

Two-client arbiter and handshake bridge that sits directly upstream of the single-port SDRAM controller. It accepts level request / one-cycle-ack transactions from two clients, A (CPU) and B (video/loader). It forwards one transaction at a time to the controller's toggle-style port (req toggles to start, ack follows req on completion). Read data is returned to the granted client together with its ack pulse.

## Interface

- ROUND_ROBIN, 1: 1 = alternate grants when both clients are pending; 0 = A always wins.

- clk  in  1  system/SDRAM clock; everything is synchronous to its rising edge.
- reset  in  1  synchronous, active-high reset; one clock, synchronous reset, active-high.
- a_req  in  1  client A request level; held until a_ack.
- a_we  in  1  1 = write, 0 = read.
- a_addr  in  21  word address [21:1].
- a_ds  in  2  byte enables {upper, lower}, active-high.
- a_d  in  16  write data.
- a_q  out  16  read data, valid in the a_ack cycle and held until the next A read completes.
- a_ack  out  1  one-cycle completion pulse.
- b_req, b_we, b_addr, b_ds, b_d, b_q, b_ack: same as A, for client B.
- mem_req  out  1  toggle request to the controller.
- mem_ack  in  1  toggle acknowledge from the controller; equals mem_req when idle/done.
- mem_we, mem_a[21:1], mem_ds[1:0], mem_d[15:0]  out  latched transaction fields; stable while mem_req != mem_ack.
- mem_q  in  16  controller read data; valid in the cycle mem_ack becomes equal to mem_req.

## Operation

- States: IDLE, BUSY.
- IDLE:
  - If any request is pending, choose a winner:
    - only one client pending: that client wins.
    - both pending, ROUND_ROBIN=1: the client not granted last wins. `last` resets to B, so A wins the first contention.
    - both pending, ROUND_ROBIN=0: A wins.
  - Latch the winner's we/addr/ds/d into the mem_* registers.
  - Set mem_req <= ~mem_ack.
  - Record grant owner; update `last`; go to BUSY.
- BUSY:
  - Wait for mem_ack == mem_req.
  - On that cycle:
    - if the transaction was a read, copy mem_q into the owner's q register;
    - pulse the owner's ack;
    - return to IDLE.
  - The non-owner's request is ignored until IDLE.
- Client obligation: drop req in the cycle after ack, or keep it high to request a new transaction. The arbiter re-samples requests in IDLE.
- No client can be re-granted within the ack cycle itself. The earliest re-issue is one cycle after ack.
- Writes return no data; the owner's q is unchanged.
- mem_ack may toggle while the arbiter is in IDLE, as a stale completion after reset. It is ignored, because each issue derives mem_req from the current mem_ack.

## Timing

- Reset values:
  - mem_req = mem_ack as sampled, re-copied every reset cycle, so the controller sees no pending request;
  - state IDLE, a_ack = b_ack = 0, a_q = b_q = 0;
  - mem_we = 0, mem_a = 0, mem_ds = 0, mem_d = 0, `last` = B.
- Reset mid-BUSY:
  - The transaction is abandoned and no ack pulse is generated.
  - The controller's in-flight completion writes ack equal to the already-resynced req and produces no toggle; its data is discarded.
- Issue latency: req seen high in IDLE at edge n → mem_req toggles and mem_* valid after edge n.
- Completion: mem_ack == mem_req first sampled at edge m → x_ack = 1 and x_q valid after edge m, for exactly one cycle.
- Arbiter overhead: 1 cycle issue + 1 cycle completion, plus 1 IDLE cycle between transactions.
- Simultaneous events:
  - a_req and b_req rising on the same edge: resolved by the priority rule.
  - A request arriving during BUSY: waits; it is never lost as long as req is held.

## Test plan

- Single A read, addr 0x012345, controller model returns 0xBEEF with its ack 6 cycles after mem_req → mem_a = 0x012345, mem_we = 0; one a_ack pulse; a_q = 0xBEEF; b_ack stays 0.
- B write, addr 0x1FFFFF, ds = 2'b01, d = 0x00A5 → mem_ds = 01, mem_d = 0x00A5; b_ack pulses once; b_q unchanged (0).
- A and B both request continuously for 6 transactions, ROUND_ROBIN=1 → grant order A,B,A,B,A,B. With ROUND_ROBIN=0 → all A until a_req is dropped.
- Power-up with mem_ack = 1, then reset → mem_req = 1 after reset; the first A request drives mem_req = 0 and completes normally.
- Reset asserted 2 cycles after issue, and the model then completes → no a_ack; no spurious issue; the next A read after reset completes with correct data.
- A held high across its ack (back-to-back) with B idle → second issue exactly 2 cycles after the first a_ack edge; each transaction produces exactly one a_ack.
